dmem_responder: RTL and testbench

//  Data-memory responder: the memory-side end of the load/store interface driven by the LSU.

---
 rtl/dmem_responder.sv | 127 ++++++++++++
 tb/tb_dmem_responder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: one valid/ready request at a time, serviced from a
// word array after a fixed latency, answered on a valid/ready response channel.
module dmem_responder #(
  parameter int unsigned    XLEN      = 64,
  parameter int unsigned    DEPTH     = 256,
  parameter logic [XLEN-1:0] BASE_ADDR = 'h8000_0000,
  parameter int unsigned    LATENCY   = 2,
  parameter                 INIT_FILE = ""
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [7:0]      req_wmask,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned LANES = XLEN / 8;
  localparam logic [XLEN-1:0] LIMIT = BASE_ADDR + XLEN'(DEPTH * 8);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  logic [XLEN-1:0] mem [DEPTH];

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               we_q, we_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               inr_q, inr_d;
  logic               resp_valid_d;
  logic [XLEN-1:0]    resp_rdata_d;
  logic               resp_err_d;

  logic               accept_c;
  logic               in_range_c;
  logic [IDX_W-1:0]   idx_c;

  assign req_ready = (state == S_IDLE) & rst_n;

  // Full-width unsigned range check, so high address bits never alias into the array.
  always_comb begin
    accept_c   = req_valid & req_ready;
    in_range_c = (req_addr >= BASE_ADDR) && (req_addr < LIMIT);
    idx_c      = IDX_W'((req_addr - BASE_ADDR) >> 3);
  end

  // Stores commit on the accept edge so any later load observes them.
  always_ff @(posedge clk) begin
    if (accept_c && req_we && in_range_c) begin
      for (int i = 0; i < LANES; i++) begin
        if (req_wmask[i]) mem[idx_c][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      idx_q      <= '0;
      inr_q      <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      we_q       <= we_d;
      idx_q      <= idx_d;
      inr_q      <= inr_d;
      resp_valid <= resp_valid_d;
      resp_rdata <= resp_rdata_d;
      resp_err   <= resp_err_d;
    end
  end

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    we_d         = we_q;
    idx_d        = idx_q;
    inr_d        = inr_q;
    resp_valid_d = resp_valid;
    resp_rdata_d = resp_rdata;
    resp_err_d   = resp_err;
    case (state)
      S_IDLE: begin
        if (accept_c) begin
          we_d    = req_we;
          idx_d   = idx_c;
          inr_d   = in_range_c;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt == '0) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = (!we_q && inr_q) ? mem[idx_q] : '0;
          resp_err_d   = !inr_q;
        end else begin
          cnt_d = cnt - CNT_W'(1);
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed and randomized transactions checked against
// a word-array reference model with address-range and byte-mask rules.
module tb_dmem_responder;

  localparam int unsigned XLEN    = 64;
  localparam int unsigned DEPTH   = 256;
  localparam int unsigned LATENCY = 2;
  localparam logic [63:0] BASE    = 64'h8000_0000;

  logic            clk;
  logic            rst_n;
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic [7:0]      req_wmask;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_err;

  int checks;
  int failures;
  logic [63:0] ref_mem [DEPTH];

  dmem_responder #(
    .XLEN(XLEN), .DEPTH(DEPTH), .BASE_ADDR(BASE), .LATENCY(LATENCY), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit in_rng(input logic [63:0] addr);
    return (addr >= BASE) && (addr < BASE + 64'(DEPTH) * 64'd8);
  endfunction

  function automatic int word_of(input logic [63:0] addr);
    return int'((addr - BASE) / 64'd8);
  endfunction

  // One full transaction; while the responder is busy, a bogus store is presented
  // to confirm that requests are ignored whenever req_ready is low.
  task automatic txn(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                     input logic [7:0] wmask, input int hold, input string tag);
    logic [63:0] exp_d;
    logic        exp_e;
    int          n;
    @(negedge clk);
    check({tag, ":req_ready_idle"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wmask = wmask;
    @(posedge clk);
    exp_e = !in_rng(addr);
    if (we && !exp_e) begin
      for (int b = 0; b < 8; b++)
        if (wmask[b]) ref_mem[word_of(addr)][8*b +: 8] = wdata[8*b +: 8];
    end
    exp_d = (!we && !exp_e) ? ref_mem[word_of(addr)] : 64'd0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1;
    req_addr  = BASE + 64'($urandom_range(0, DEPTH - 1)) * 64'd8;
    req_wdata = {$urandom, $urandom}; req_wmask = 8'hFF;
    check({tag, ":req_ready_busy"}, 64'(req_ready), 64'd0);
    n = 0;
    while (!resp_valid && n < 20) begin
      @(posedge clk); n++; @(negedge clk);
    end
    check({tag, ":latency"}, 64'(n), 64'(LATENCY));
    check({tag, ":rdata"}, resp_rdata, exp_d);
    check({tag, ":err"}, 64'(resp_err), 64'(exp_e));
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); @(negedge clk);
      check({tag, ":hold_valid"}, 64'(resp_valid), 64'd1);
      check({tag, ":hold_rdata"}, resp_rdata, exp_d);
      check({tag, ":hold_ready"}, 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    resp_ready = 1'b0; req_valid = 1'b0;
    check({tag, ":post_valid"}, 64'(resp_valid), 64'd0);
    check({tag, ":post_rdata"}, resp_rdata, 64'd0);
    check({tag, ":post_err"}, 64'(resp_err), 64'd0);
    check({tag, ":post_ready"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] a;
    checks = 0; failures = 0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 64'd0;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
    req_wdata = '0; req_wmask = '0; resp_ready = 1'b0;

    repeat (3) begin
      @(negedge clk);
      check("rst:req_ready", 64'(req_ready), 64'd0);
      check("rst:resp_valid", 64'(resp_valid), 64'd0);
      check("rst:resp_rdata", resp_rdata, 64'd0);
    end
    rst_n = 1'b1;
    #1 check("rst:release_ready", 64'(req_ready), 64'd1);

    txn(1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 8'hFF, 0, "st_full");
    txn(1'b0, 64'h8000_0013, 64'd0, 8'h00, 0, "ld_full");
    check("ld_full:value", resp_rdata === 64'd0 ? ref_mem[2] : 64'd0, 64'h1122_3344_5566_7788);
    txn(1'b1, 64'h8000_0010, 64'h0000_00AA_0000_0000, 8'h10, 0, "st_mask");
    txn(1'b0, 64'h8000_0010, 64'd0, 8'h00, 0, "ld_mask");
    txn(1'b1, 64'h8000_0018, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF, 0, "st_w3");
    txn(1'b1, 64'h8000_0018, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 0, "st_nomask");
    txn(1'b0, 64'h8000_0018, 64'd0, 8'h00, 0, "ld_nomask");
    txn(1'b0, 64'h8000_0010, 64'd0, 8'h00, 5, "backpressure");

    txn(1'b1, 64'h8000_0000, 64'h0101_0101_0101_0101, 8'hFF, 0, "st_w0");
    txn(1'b1, 64'h8000_07F8, 64'h0202_0202_0202_0202, 8'hFF, 0, "st_last");
    txn(1'b0, 64'h8000_07F8, 64'd0, 8'h00, 0, "ld_last");
    txn(1'b0, 64'h8000_0800, 64'd0, 8'h00, 0, "ld_oor_top");
    txn(1'b1, 64'h7FFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, "st_oor_low");
    txn(1'b1, 64'h8000_0800, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, "st_oor_top");
    txn(1'b1, 64'h1_8000_0010, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, "st_oor_high");
    txn(1'b0, 64'h8000_0000, 64'd0, 8'h00, 0, "ld_w0_after_oor");
    txn(1'b0, 64'h8000_0010, 64'd0, 8'h00, 0, "ld_w2_after_oor");
    txn(1'b0, 64'h8000_07F8, 64'd0, 8'h00, 0, "ld_last_after_oor");

    // Reset while a load is waiting: the response must never appear.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 64'h8000_0010;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; rst_n = 1'b0;
    check("rst_wait:req_ready_low", 64'(req_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < LATENCY + 3; k++) begin
      @(posedge clk); @(negedge clk);
      check("rst_wait:no_resp", 64'(resp_valid), 64'd0);
      check("rst_wait:ready", 64'(req_ready), 64'd1);
    end
    txn(1'b0, 64'h8000_0010, 64'd0, 8'h00, 0, "rst_wait:reload");

    for (int i = 0; i < DEPTH; i++)
      txn(1'b1, BASE + 64'(i) * 64'd8, {$urandom, $urandom}, 8'hFF, 0, "fill");

    for (int t = 0; t < 80; t++) begin
      case ($urandom_range(0, 9))
        8:       a = BASE - 64'd8 * 64'($urandom_range(1, 16));
        9:       a = BASE + 64'(DEPTH) * 64'd8 + 64'($urandom_range(0, 255));
        default: a = BASE + 64'($urandom_range(0, DEPTH * 8 - 1));
      endcase
      txn(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, 8'($urandom_range(0, 255)),
          $urandom_range(0, 3), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
